// File: rtl/relu_seq_ctrl.sv
// relu_seq_ctrl
// Sequencing controller for one ReLU stage. It streams num_elems
// consecutive read addresses into the ReLU unit. It then produces write
// strobes and addresses aligned to the registered ReLU output. It also
// counts negative (clamped) inputs for sparsity statistics.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-low reset
//   start             run request, accepted only in IDLE or DONE
//   num_elems         element count 0..2^ADDR_WIDTH (latched on accept)
//   base_rd_addr      first read address (latched on accept)
//   base_wr_addr      first write address (latched on accept)
//   hold              pauses issue of new reads (in-flight reads complete)
//   rd_en, rd_addr    read strobe/address to source buffer
//   rd_msb            sign bit of read data, valid the cycle after rd_en
//   wr_en, wr_addr    write strobe/address to destination buffer
//   busy              high in ISSUE and DRAIN
//   done              one-cycle completion pulse
//   neg_count         negative inputs seen in the current or last run
module relu_seq_ctrl #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_elems,
  input  logic [ADDR_WIDTH-1:0] base_rd_addr,
  input  logic [ADDR_WIDTH-1:0] base_wr_addr,
  input  logic                  hold,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_msb,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   neg_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH:0]   n_q;       // latched element count
  logic [ADDR_WIDTH:0]   idx;       // issue index i
  logic [ADDR_WIDTH-1:0] wr_base_q;
  logic [ADDR_WIDTH-1:0] off1;      // write offset, stage 1 (memory read)
  logic                  vld1;      // valid, stage 1; wr_en is stage 2

  logic accept, issue, last_issue;

  assign accept     = start && (state == S_IDLE || state == S_DONE);
  // hold gates the strobe in the same cycle, so a hold cycle is a
  // bubble in that cycle rather than in the following one.
  assign issue      = (state == S_ISSUE) && !hold;
  assign last_issue = issue && (idx == n_q - 1'b1);

  assign rd_en = issue;
  assign busy  = (state == S_ISSUE) || (state == S_DRAIN);
  assign done  = (state == S_DONE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      n_q       <= '0;
      idx       <= '0;
      rd_addr   <= '0;
      wr_base_q <= '0;
      off1      <= '0;
      vld1      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      neg_count <= '0;
    end else begin
      // in-flight pipe runs independently of hold
      vld1  <= issue;
      wr_en <= vld1;
      if (issue) off1 <= idx[ADDR_WIDTH-1:0];
      if (vld1)  wr_addr <= wr_base_q + off1;

      if (accept) begin
        n_q       <= num_elems;
        idx       <= '0;
        rd_addr   <= base_rd_addr;
        wr_base_q <= base_wr_addr;
        neg_count <= '0;
      end else begin
        if (issue) begin
          idx     <= idx + 1'b1;
          rd_addr <= rd_addr + 1'b1;  // wraps modulo 2^ADDR_WIDTH
        end
        // vld1 marks the cycle where rd_msb belongs to an issued read
        if (vld1 && rd_msb) neg_count <= neg_count + 1'b1;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (accept) state <= (num_elems == '0) ? S_DONE : S_ISSUE;
          else        state <= S_IDLE;
        end
        S_ISSUE: if (last_issue) state <= S_DRAIN;
        // stage 2 (wr_en) drains during the DRAIN->DONE edge itself
        S_DRAIN: if (!vld1) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_seq_ctrl.sv
// Self-checking bench for relu_seq_ctrl: table-driven runs plus
// hand-written sequences for long runs, back-to-back start and reset.
module tb_relu_seq_ctrl;
  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset, start, hold, rd_msb;
  logic [AW:0]   num_elems;
  logic [AW-1:0] base_rd_addr, base_wr_addr;
  logic          rd_en, wr_en, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [AW:0]   neg_count;

  relu_seq_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .num_elems(num_elems),
    .base_rd_addr(base_rd_addr), .base_wr_addr(base_wr_addr), .hold(hold),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_msb(rd_msb), .wr_en(wr_en),
    .wr_addr(wr_addr), .busy(busy), .done(done), .neg_count(neg_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int            n;
    logic [AW-1:0] rd_base;
    logic [AW-1:0] wr_base;
    logic [31:0]   msb_pat;  // bit j = sign of element j
    logic [15:0]   hold_m;   // per-cycle hold
    logic [15:0]   start_m;  // extra start pulses (cycle >= 1)
    logic [15:0]   rd_m;     // expected rd_en per cycle
    logic [15:0]   wr_m;     // expected wr_en per cycle
    int            done_cyc;
    int            neg;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // advance to the start of the next cycle
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // called at the start of cycle 0; runs 16 cycles
  task automatic run_vec(input vec_t v, input string tag);
    int ri = 0;
    int wi = 0;
    int last = -1;
    logic [AW-1:0] ea;
    for (int k = 0; k < 16; k++) begin
      start        = (k == 0) ? 1'b1 : v.start_m[k];
      num_elems    = v.n[AW:0];
      base_rd_addr = v.rd_base;
      base_wr_addr = v.wr_base;
      hold         = v.hold_m[k];
      // sign bit of the read issued last cycle; 1 when no read is
      // in flight so that ungated counting would be visible
      rd_msb       = (last >= 0) ? v.msb_pat[last] : 1'b1;
      @(negedge clock);
      check($sformatf("%s rd_en c%0d", tag, k), rd_en, v.rd_m[k]);
      if (v.rd_m[k]) begin
        ea = v.rd_base + ri[AW-1:0];
        check($sformatf("%s rd_addr c%0d", tag, k), rd_addr, ea);
        last = ri;
        ri++;
      end else last = -1;
      check($sformatf("%s wr_en c%0d", tag, k), wr_en, v.wr_m[k]);
      if (v.wr_m[k]) begin
        ea = v.wr_base + wi[AW-1:0];
        check($sformatf("%s wr_addr c%0d", tag, k), wr_addr, ea);
        wi++;
      end
      check($sformatf("%s done c%0d", tag, k), done, k == v.done_cyc);
      check($sformatf("%s busy c%0d", tag, k), busy,
            v.n > 0 && k >= 1 && k < v.done_cyc);
      if (k == v.done_cyc)
        check($sformatf("%s neg_count", tag), neg_count, v.neg);
      next_cycle();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rd_en"}, rd_en, 0);
    check({tag, " rd_addr"}, rd_addr, 0);
    check({tag, " wr_en"}, wr_en, 0);
    check({tag, " wr_addr"}, wr_addr, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " neg_count"}, neg_count, 0);
  endtask

  initial begin
    int rdc, wrc, dcyc;
    logic [AW-1:0] last_rd;

    //        n  rd_base  wr_base  msb    hold    start   rd_m    wr_m   done neg
    vecs[0] = '{4, 10'h010, 10'h200, 32'h6,  16'h0,  16'h0,  16'h001E, 16'h0078, 7, 2};
    vecs[1] = '{0, 10'h123, 10'h055, 32'h0,  16'h0,  16'h0,  16'h0000, 16'h0000, 1, 0};
    vecs[2] = '{3, 10'h3FE, 10'h3FF, 32'h5,  16'h0,  16'h0,  16'h000E, 16'h0038, 6, 2};
    vecs[3] = '{5, 10'h0A0, 10'h0B0, 32'h1F, 16'h000C, 16'h0010, 16'h00F2, 16'h03C8, 10, 5};
    vecs[4] = '{2, 10'h050, 10'h060, 32'h2,  16'h0,  16'h0,  16'h0006, 16'h0018, 5, 1};

    reset = 1'b0; start = 1'b0; hold = 1'b0; rd_msb = 1'b0;
    num_elems = '0; base_rd_addr = '0; base_wr_addr = '0;
    next_cycle();
    next_cycle();
    @(negedge clock);
    check_all_zero("reset");
    next_cycle();
    reset = 1'b1;
    next_cycle();

    for (int v = 0; v < 4; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // N=1024, every input negative, then back-to-back start in DONE
    rdc = 0; wrc = 0; dcyc = -1; last_rd = '0;
    for (int k = 0; k < 1100 && dcyc < 0; k++) begin
      start = (k == 0); num_elems = 11'd1024;
      base_rd_addr = 10'h100; base_wr_addr = 10'h300;
      hold = 1'b0; rd_msb = 1'b1;
      @(negedge clock);
      if (rd_en) begin rdc++; last_rd = rd_addr; end
      if (wr_en) wrc++;
      if (done) dcyc = k;
      else next_cycle();
    end
    check("full done_cycle", dcyc, 1027);
    check("full rd count", rdc, 1024);
    check("full wr count", wrc, 1024);
    check("full last rd_addr", last_rd, 10'h0FF);
    check("full neg_count", neg_count, 1024);
    // still inside the DONE cycle: request the second run
    start = 1'b1; num_elems = 11'd2; base_rd_addr = 10'h020; base_wr_addr = 10'h040;
    rd_msb = 1'b0;
    next_cycle();
    start = 1'b0;
    @(negedge clock);
    check("b2b rd_en c1", rd_en, 1);
    check("b2b rd_addr c1", rd_addr, 10'h020);
    check("b2b neg clear", neg_count, 0);
    check("b2b busy c1", busy, 1);
    next_cycle();
    rd_msb = 1'b1;
    @(negedge clock);
    check("b2b rd_addr c2", rd_addr, 10'h021);
    next_cycle();
    rd_msb = 1'b0;
    @(negedge clock);
    check("b2b wr_en c3", wr_en, 1);
    check("b2b wr_addr c3", wr_addr, 10'h040);
    next_cycle();
    @(negedge clock);
    check("b2b wr_addr c4", wr_addr, 10'h041);
    next_cycle();
    @(negedge clock);
    check("b2b done c5", done, 1);
    check("b2b neg_count", neg_count, 1);
    next_cycle();
    next_cycle();

    // N=8 with reset sampled in cycle 4
    for (int k = 0; k < 5; k++) begin
      start = (k == 0); num_elems = 11'd8;
      base_rd_addr = 10'h080; base_wr_addr = 10'h090;
      hold = 1'b0; rd_msb = 1'b1;
      if (k == 4) reset = 1'b0;
      @(negedge clock);
      if (k == 4) check("rst neg before", neg_count, 2);
      next_cycle();
    end
    reset = 1'b1;
    @(negedge clock);
    check_all_zero("rst c5");
    for (int k = 6; k < 9; k++) begin
      next_cycle();
      @(negedge clock);
      check($sformatf("rst wr_en c%0d", k), wr_en, 0);
      check($sformatf("rst busy c%0d", k), busy, 0);
    end
    next_cycle();
    run_vec(vecs[4], "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
